// File: rtl/fetch_ctrl_pkg.sv
// Shared opcode, field-position and state definitions for the fetch stage.
package fetch_ctrl_pkg;

    localparam logic [3:0] OP_GOTO = 4'b1000;
    localparam logic [3:0] OP_CALL = 4'b1001;
    localparam logic [3:0] OP_RET  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int PARAM_MSB = 7;
    localparam int PARAM_LSB = 0;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_rstack.sv
// Return-address LIFO for call/ret; contents are don't-care after reset, only sp is cleared.
module fetch_rstack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_pushData,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [IDXW-1:0]  w_topIdx;
    logic [IDXW-1:0]  w_pushIdx;

    assign w_topIdx  = IDXW'(r_sp - SPW'(1));
    assign w_pushIdx = IDXW'(r_sp);
    assign o_full    = (r_sp == SPW'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign o_top     = r_mem[w_topIdx];

    always_ff @(posedge clk) begin
        if (res) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SPW'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_pushIdx] <= i_pushData;
        end
    end

    // Only one opcode is decoded per cycle, so both strobes together means a broken caller.
    always @(posedge clk) begin
        if (!res) begin
            assert (!(i_push && i_pop))
                else $error("fetch_rstack: simultaneous push and pop");
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: drives pc, resolves goto/call/ret/halt locally and issues datapath words to the decoder.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int IR_WIDTH    = 16,
    parameter int CMD_CNT     = 64,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                res,
    output logic [PC_WIDTH-1:0] pc_o,
    input  logic [IR_WIDTH-1:0] ir_i,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic [PC_WIDTH-1:0] ir_pc_o,
    output logic                ir_valid,
    input  logic                ir_ready,
    input  logic                resume,
    output logic                halted,
    output logic                err
);

    localparam logic [PC_WIDTH:0] CMD_LIMIT = (PC_WIDTH + 1)'(CMD_CNT);

    state_t              r_state;
    state_t              w_nextState;
    logic [PC_WIDTH-1:0] r_pc;
    logic [IR_WIDTH-1:0] r_irO;
    logic [PC_WIDTH-1:0] r_irPc;
    logic                r_irValid;

    logic [3:0]          w_opcode;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_retAddr;
    logic                w_inRange;
    logic                w_advance;
    logic                w_fetch;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    assign w_opcode  = ir_i[OPC_MSB:OPC_LSB];
    assign w_target  = ir_i[PARAM_LSB +: PC_WIDTH];
    assign w_inRange = ({1'b0, r_pc} < CMD_LIMIT);
    assign w_advance = !r_irValid || ir_ready;
    assign w_fetch   = (r_state == S_RUN) && w_inRange && w_advance;
    assign w_push    = w_fetch && (w_opcode == OP_CALL) && !w_full;
    assign w_pop     = w_fetch && (w_opcode == OP_RET) && !w_empty;

    fetch_rstack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_rstack (
        .clk        (clk),
        .res        (res),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_pushData (r_pc + PC_WIDTH'(1)),
        .o_top      (w_retAddr),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An out-of-range pc faults even while stalled, so nothing is ever fetched from it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_RUN: begin
                if (!w_inRange) begin
                    w_nextState = S_ERR;
                end else if (w_advance) begin
                    if ((w_opcode == OP_CALL) && w_full) begin
                        w_nextState = S_ERR;
                    end else if ((w_opcode == OP_RET) && w_empty) begin
                        w_nextState = S_ERR;
                    end else if (w_opcode == OP_HALT) begin
                        w_nextState = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_nextState = S_RUN;
                end
            end
            S_ERR:   w_nextState = S_ERR;
            default: w_nextState = S_ERR;
        endcase
    end

    always_comb begin
        halted = (r_state != S_RUN);
        err    = (r_state == S_ERR);
    end

    // Whenever nothing new is issued the output register simply drains on ir_ready.
    always_ff @(posedge clk) begin
        if (res) begin
            r_pc      <= '0;
            r_irO     <= '0;
            r_irPc    <= '0;
            r_irValid <= 1'b0;
        end else begin
            r_irValid <= r_irValid && !ir_ready;
            if (w_fetch) begin
                case (w_opcode)
                    OP_GOTO: r_pc <= w_target;
                    OP_CALL: if (!w_full) r_pc <= w_target;
                    OP_RET:  if (!w_empty) r_pc <= w_retAddr;
                    OP_HALT: r_pc <= r_pc;
                    default: begin
                        r_irO     <= ir_i;
                        r_irPc    <= r_pc;
                        r_irValid <= 1'b1;
                        r_pc      <= r_pc + PC_WIDTH'(1);
                    end
                endcase
            end else if ((r_state == S_HALT) && resume) begin
                r_pc <= r_pc + PC_WIDTH'(1);
            end
        end
    end

    assign pc_o     = r_pc;
    assign ir_o     = r_irO;
    assign ir_pc_o  = r_irPc;
    assign ir_valid = r_irValid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural program memory feeds ir_i from pc_o combinationally.
module tb_fetch_ctrl;

    logic        clk;
    logic        res;
    logic [7:0]  pc_o;
    logic [15:0] ir_i;
    logic [15:0] ir_o;
    logic [7:0]  ir_pc_o;
    logic        ir_valid;
    logic        ir_ready;
    logic        resume;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:255];
    int          nAsserts;
    int          nFails;

    fetch_ctrl #(
        .PC_WIDTH    (8),
        .IR_WIDTH    (16),
        .CMD_CNT     (64),
        .STACK_DEPTH (4)
    ) dut (
        .clk      (clk),
        .res      (res),
        .pc_o     (pc_o),
        .ir_i     (ir_i),
        .ir_o     (ir_o),
        .ir_pc_o  (ir_pc_o),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .resume   (resume),
        .halted   (halted),
        .err      (err)
    );

    assign ir_i = mem[pc_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rdy, input logic rsm, input logic rst);
        ir_ready = rdy;
        resume   = rsm;
        res      = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
            else begin
                nFails++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        clearMem();
        ir_ready = 1'b1;
        resume   = 1'b0;
        res      = 1'b1;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("reset_pc", pc_o, 0);
        checkOutput("reset_valid", ir_valid, 0);
        checkOutput("reset_ir", ir_o, 0);
        checkOutput("reset_irpc", ir_pc_o, 0);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_err", err, 0);

        // Straight line: val/val/add/nop at 0..3
        mem[0] = 16'h1005;
        mem[1] = 16'h1003;
        mem[2] = 16'h2000;
        mem[3] = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("line0_valid", ir_valid, 1);
        checkOutput("line0_irpc", ir_pc_o, 0);
        checkOutput("line0_ir", ir_o, 16'h1005);
        checkOutput("line0_pc", pc_o, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("line1_irpc", ir_pc_o, 1);
        checkOutput("line1_ir", ir_o, 16'h1003);
        checkOutput("line1_pc", pc_o, 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("line2_irpc", ir_pc_o, 2);
        checkOutput("line2_ir", ir_o, 16'h2000);
        checkOutput("line2_pc", pc_o, 3);

        // Stall three cycles at ir_pc_o=2
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("stall_valid", ir_valid, 1);
            checkOutput("stall_irpc", ir_pc_o, 2);
            checkOutput("stall_ir", ir_o, 16'h2000);
            checkOutput("stall_pc", pc_o, 3);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("release_irpc", ir_pc_o, 3);
        checkOutput("release_valid", ir_valid, 1);
        checkOutput("release_pc", pc_o, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("release_next_irpc", ir_pc_o, 4);

        // Reset during a stall with a pending instruction
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("prereset_valid", ir_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midreset_valid", ir_valid, 0);
        checkOutput("midreset_pc", pc_o, 0);
        checkOutput("midreset_err", err, 0);

        // Goto loop: 0 goto 8; 8 nop; 9 nop; 10 goto 8
        clearMem();
        mem[0]  = 16'h8008;
        mem[10] = 16'h8008;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("goto_entry_pc", pc_o, 8);
        checkOutput("goto_entry_valid", ir_valid, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("loop_a_irpc", ir_pc_o, 8);
            checkOutput("loop_a_ir", ir_o, 16'h0000);
            checkOutput("loop_a_pc", pc_o, 9);
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("loop_b_irpc", ir_pc_o, 9);
            checkOutput("loop_b_valid", ir_valid, 1);
            checkOutput("loop_b_pc", pc_o, 10);
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("loop_bubble_valid", ir_valid, 0);
            checkOutput("loop_bubble_pc", pc_o, 8);
            checkOutput("loop_bubble_ir", ir_o, 16'h0000);
        end

        // Call/ret: 0 call 20; 20 val; 21 ret; 1 add; 2 ret on an empty stack
        clearMem();
        mem[0]  = 16'h9014;
        mem[1]  = 16'h2000;
        mem[2]  = 16'hA000;
        mem[20] = 16'h1007;
        mem[21] = 16'hA000;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("call_pc", pc_o, 20);
        checkOutput("call_valid", ir_valid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("callee_irpc", ir_pc_o, 20);
        checkOutput("callee_ir", ir_o, 16'h1007);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ret_pc", pc_o, 1);
        checkOutput("ret_valid", ir_valid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("after_ret_irpc", ir_pc_o, 1);
        checkOutput("after_ret_ir", ir_o, 16'h2000);
        checkOutput("after_ret_err", err, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ret_empty_err", err, 1);
        checkOutput("ret_empty_halted", halted, 1);
        checkOutput("ret_empty_valid", ir_valid, 0);

        // Five nested calls overflow the 4-deep stack
        clearMem();
        mem[0] = 16'h9001;
        mem[1] = 16'h9002;
        mem[2] = 16'h9003;
        mem[3] = 16'h9004;
        mem[4] = 16'h9005;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("nest_pc", pc_o, i);
            checkOutput("nest_err", err, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("overflow_err", err, 1);
        checkOutput("overflow_halted", halted, 1);
        checkOutput("overflow_pc", pc_o, 4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("resume_in_err_err", err, 1);
        checkOutput("resume_in_err_pc", pc_o, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("err_hold_pc", pc_o, 4);
        checkOutput("err_hold_halted", halted, 1);

        // Halt at 5, resume later
        clearMem();
        mem[5] = 16'hF000;
        mem[6] = 16'h1006;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("prehalt_irpc", ir_pc_o, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_pc", pc_o, 5);
        checkOutput("halt_valid", ir_valid, 0);
        checkOutput("halt_err", err, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("halt_hold_halted", halted, 1);
        checkOutput("halt_hold_pc", pc_o, 5);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("resume_halted", halted, 0);
        checkOutput("resume_pc", pc_o, 6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_irpc", ir_pc_o, 6);
        checkOutput("resume_ir", ir_o, 16'h1006);
        checkOutput("resume_valid", ir_valid, 1);

        // Range fault: goto 64 with 64 valid entries
        clearMem();
        mem[0]  = 16'h8040;
        mem[64] = 16'h1040;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("range_pc", pc_o, 64);
        checkOutput("range_pre_err", err, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("range_err", err, 1);
        checkOutput("range_halted", halted, 1);
        checkOutput("range_valid", ir_valid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("range_no_issue", ir_valid, 0);
        checkOutput("range_ir", ir_o, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
